// File: rtl/frame_capture_ctrl.sv
// frame_capture_ctrl: arms on request, waits for a vsync falling edge, then
// writes the synchronised comparator sample of every pixel inside the
// CAP_COLS x CAP_ROWS window into display RAM until the next vsync falling
// edge ends the frame.
module frame_capture_ctrl #(
    parameter int CAP_COLS = 256,
    parameter int CAP_ROWS = 256
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        arm,
    input  logic        continuous,
    input  logic        abort,
    input  logic        vsync_in,
    input  logic        visible,
    input  logic [11:0] display_col,
    input  logic [10:0] display_row,
    input  logic [2:0]  sample_in,
    output logic        wr_en,
    output logic [15:0] wr_addr,
    output logic [2:0]  wr_data,
    output logic        busy,
    output logic        done,
    output logic [16:0] wr_count,
    output logic [7:0]  frame_count
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_VS,
        CAPTURE,
        DONE
    } state_t;

    localparam logic [11:0] COL_LIMIT = 12'(CAP_COLS);
    localparam logic [10:0] ROW_LIMIT = 11'(CAP_ROWS);
    localparam logic [16:0] WR_MAX    = 17'd65536;

    state_t      state;
    logic        vs_s1, vs_s2, vs_s3;
    logic        vs_fall;
    logic [2:0]  smp_s1, smp_s2;
    logic        pix_ok;

    // Two-flop synchronisers plus a registered falling-edge pulse on vsync
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vs_s1   <= 1'b1;
            vs_s2   <= 1'b1;
            vs_s3   <= 1'b1;
            vs_fall <= 1'b0;
            smp_s1  <= '0;
            smp_s2  <= '0;
        end else begin
            vs_s1   <= vsync_in;
            vs_s2   <= vs_s1;
            vs_s3   <= vs_s2;
            vs_fall <= vs_s3 & ~vs_s2;
            smp_s1  <= sample_in;
            smp_s2  <= smp_s1;
        end
    end

    // Pixel lies inside the capture window
    always_comb begin
        pix_ok = visible && (display_col < COL_LIMIT) && (display_row < ROW_LIMIT);
    end

    // Capture FSM with registered write port, status and counters
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            wr_count    <= '0;
            frame_count <= '0;
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
            // A write already on the port still counts even if abort arrives now
            if (wr_en && (wr_count != WR_MAX)) begin
                wr_count <= wr_count + 17'd1;
            end
            if (abort) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (arm) begin
                            state <= WAIT_VS;
                            busy  <= 1'b1;
                        end
                    end
                    WAIT_VS: begin
                        if (vs_fall) begin
                            state    <= CAPTURE;
                            wr_count <= '0;
                        end
                    end
                    CAPTURE: begin
                        if (pix_ok) begin
                            wr_en   <= 1'b1;
                            wr_addr <= {display_col[7:0], display_row[7:0]};
                            wr_data <= smp_s2;
                        end
                        if (vs_fall) begin
                            state       <= DONE;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            frame_count <= frame_count + 8'd1;
                        end
                    end
                    DONE: begin
                        if (continuous) begin
                            state <= WAIT_VS;
                            busy  <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Directed bench for frame_capture_ctrl using a reduced 16x16 capture window.
module tb_frame_capture_ctrl;

    localparam int CAPC = 16;
    localparam int CAPR = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        arm = 1'b0;
    logic        continuous = 1'b0;
    logic        abort = 1'b0;
    logic        vsync_in = 1'b1;
    logic        visible = 1'b0;
    logic [11:0] display_col = '0;
    logic [10:0] display_row = '0;
    logic [2:0]  sample_in = 3'b101;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [2:0]  wr_data;
    logic        busy;
    logic        done;
    logic [16:0] wr_count;
    logic [7:0]  frame_count;

    int n_checks = 0;
    int n_fail = 0;
    int n_wr = 0;
    int n_bad = 0;
    int n_done = 0;

    logic [11:0] p_col = '0;
    logic [10:0] p_row = '0;
    logic        p_vis = 1'b0;
    logic [2:0]  exp_sample = 3'b101;

    frame_capture_ctrl #(.CAP_COLS(CAPC), .CAP_ROWS(CAPR)) dut (
        .clock       (clock),
        .reset       (reset),
        .arm         (arm),
        .continuous  (continuous),
        .abort       (abort),
        .vsync_in    (vsync_in),
        .visible     (visible),
        .display_col (display_col),
        .display_row (display_row),
        .sample_in   (sample_in),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .busy        (busy),
        .done        (done),
        .wr_count    (wr_count),
        .frame_count (frame_count)
    );

    always #5 clock = ~clock;

    // Each write must match the pixel presented exactly one cycle earlier
    always @(negedge clock) begin
        if (wr_en) begin
            n_wr++;
            if (!p_vis || p_col >= 12'(CAPC) || p_row >= 11'(CAPR) ||
                wr_addr != {p_col[7:0], p_row[7:0]} || wr_data != exp_sample)
                n_bad++;
        end
        if (done) n_done++;
        p_col = display_col;
        p_row = display_row;
        p_vis = visible;
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_mon();
        n_wr = 0;
        n_bad = 0;
        n_done = 0;
    endtask

    task automatic pulse_arm();
        tick();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    // vs_fall is registered three edges after vsync drops; arm_at_fall lands arm on the fourth
    task automatic vsync_pulse(input bit arm_at_fall);
        tick();
        vsync_in = 1'b0;
        tick();
        tick();
        tick();
        if (arm_at_fall) arm = 1'b1;
        tick();
        arm = 1'b0;
        tick();
        vsync_in = 1'b1;
        repeat (4) tick();
    endtask

    task automatic raster(input int cols, input int rows, input int abort_row);
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < cols; c++) begin
                tick();
                display_col = 12'(c);
                display_row = 11'(r);
                visible = 1'b1;
                if (r == abort_row) begin
                    abort = 1'b1;
                    tick();
                    abort = 1'b0;
                    visible = 1'b0;
                    return;
                end
            end
        end
        tick();
        visible = 1'b0;
        display_col = '0;
        display_row = '0;
        repeat (4) tick();
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clock);
        #2;
        check_eq("rst_wr_en", 32'(wr_en), 0);
        check_eq("rst_wr_addr", 32'(wr_addr), 0);
        check_eq("rst_wr_data", 32'(wr_data), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_done", 32'(done), 0);
        check_eq("rst_wr_count", 32'(wr_count), 0);
        check_eq("rst_frame_count", 32'(frame_count), 0);
        tick();
        reset = 1'b0;
        repeat (3) tick();

        // Single capture of a window-sized raster, second frame ignored
        clear_mon();
        pulse_arm();
        @(negedge clock);
        check_eq("arm_busy", 32'(busy), 1);
        vsync_pulse(0);
        raster(CAPC, CAPR, -1);
        vsync_pulse(0);
        raster(CAPC, CAPR, -1);
        check_eq("f1_writes", 32'(n_wr), 256);
        check_eq("f1_bad", 32'(n_bad), 0);
        check_eq("f1_done", 32'(n_done), 1);
        check_eq("f1_wr_count", 32'(wr_count), 256);
        check_eq("f1_frame_count", 32'(frame_count), 1);
        check_eq("f1_idle_busy", 32'(busy), 0);

        // Wide raster clipped to the window, different sample value
        sample_in = 3'b010;
        exp_sample = 3'b010;
        clear_mon();
        pulse_arm();
        vsync_pulse(0);
        raster(40, 30, -1);
        vsync_pulse(0);
        check_eq("clip_writes", 32'(n_wr), 256);
        check_eq("clip_bad", 32'(n_bad), 0);
        check_eq("clip_wr_count", 32'(wr_count), 256);
        check_eq("clip_frame_count", 32'(frame_count), 2);

        // Continuous mode captures alternate frames
        sample_in = 3'b101;
        exp_sample = 3'b101;
        clear_mon();
        continuous = 1'b1;
        pulse_arm();
        for (int f = 0; f < 5; f++) begin
            vsync_pulse(0);
            raster(CAPC, CAPR, -1);
        end
        check_eq("cont_writes", 32'(n_wr), 768);
        check_eq("cont_bad", 32'(n_bad), 0);
        check_eq("cont_done", 32'(n_done), 2);
        check_eq("cont_frame_count", 32'(frame_count), 4);
        check_eq("cont_busy", 32'(busy), 1);
        continuous = 1'b0;
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clock);
        check_eq("cont_abort_busy", 32'(busy), 0);
        check_eq("cont_abort_wr_count", 32'(wr_count), 256);

        // Abort at row 10 of the window
        clear_mon();
        pulse_arm();
        vsync_pulse(0);
        raster(CAPC, CAPR, 10);
        @(negedge clock);
        check_eq("abort_wr_en", 32'(wr_en), 0);
        check_eq("abort_busy", 32'(busy), 0);
        check_eq("abort_wr_count", 32'(wr_count), 160);
        check_eq("abort_writes", 32'(n_wr), 160);
        vsync_pulse(0);
        raster(CAPC, CAPR, -1);
        vsync_pulse(0);
        check_eq("abort_done", 32'(n_done), 0);
        check_eq("abort_frame_count", 32'(frame_count), 4);
        check_eq("abort_wr_count_held", 32'(wr_count), 160);

        // Arm coincident with vs_fall, then arms while busy
        clear_mon();
        vsync_pulse(1);
        @(negedge clock);
        check_eq("coinc_busy", 32'(busy), 1);
        raster(CAPC, CAPR, -1);
        check_eq("coinc_no_writes", 32'(n_wr), 0);
        pulse_arm();
        vsync_pulse(0);
        raster(CAPC / 2, 1, -1);
        pulse_arm();
        raster(CAPC, CAPR, -1);
        vsync_pulse(0);
        check_eq("busy_arm_writes", 32'(n_wr), 264);
        check_eq("busy_arm_bad", 32'(n_bad), 0);
        check_eq("busy_arm_done", 32'(n_done), 1);
        check_eq("busy_arm_frame_count", 32'(frame_count), 5);
        check_eq("busy_arm_busy", 32'(busy), 0);

        // Asynchronous reset in the middle of a capture
        clear_mon();
        pulse_arm();
        vsync_pulse(0);
        for (int c = 0; c < 8; c++) begin
            tick();
            display_col = 12'(c);
            display_row = '0;
            visible = 1'b1;
        end
        #2;
        check_eq("pre_rst_wr_en", 32'(wr_en), 1);
        reset = 1'b1;
        #1;
        check_eq("mid_rst_wr_en", 32'(wr_en), 0);
        check_eq("mid_rst_wr_addr", 32'(wr_addr), 0);
        check_eq("mid_rst_wr_data", 32'(wr_data), 0);
        check_eq("mid_rst_busy", 32'(busy), 0);
        check_eq("mid_rst_wr_count", 32'(wr_count), 0);
        check_eq("mid_rst_frame_count", 32'(frame_count), 0);
        visible = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        clear_mon();
        vsync_pulse(0);
        raster(CAPC, CAPR, -1);
        vsync_pulse(0);
        check_eq("post_rst_writes", 32'(n_wr), 0);
        check_eq("post_rst_busy", 32'(busy), 0);
        check_eq("post_rst_done", 32'(n_done), 0);
        check_eq("post_rst_frame_count", 32'(frame_count), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_capture_ctrl.md
FRAME_CAPTURE_CTRL -- requirements
Module: frame_capture_ctrl

Interface
REQ-001 SHALL use parameter: CAP_COLS, 256, capture window width in pixels (power of two, max 256).
REQ-002 SHALL use parameter: CAP_ROWS, 256, capture window height in lines (power of two, max 256).
REQ-003 SHALL have port: clock  input  1  pixel clock (PLL output).
REQ-004 SHALL have port: reset  input  1  asynchronous, active-high.
REQ-005 SHALL have port: arm  input  1  single-cycle request to capture the next frame.
REQ-006 SHALL have port: continuous  input  1  1 = re-arm automatically after each frame.
REQ-007 SHALL have port: abort  input  1  cancel capture, return to IDLE.
REQ-008 SHALL have port: vsync_in  input  1  polarity-corrected active-low vsync, asynchronous to clock.
REQ-009 SHALL have port: visible  input  1  VGA controller active-area flag.
REQ-010 SHALL have port: display_col  input  12  current column from VGA controller.
REQ-011 SHALL have port: display_row  input  11  current row from VGA controller.
REQ-012 SHALL have port: sample_in  input  3  comparator bits {GPIO14, GPIO4, GPIO0}, asynchronous.
REQ-013 SHALL have port: wr_en  output  1  display RAM write enable.
REQ-014 SHALL have port: wr_addr  output  16  display RAM address {col[7:0], row[7:0]}.
REQ-015 SHALL have port: wr_data  output  3  display RAM write data.
REQ-016 SHALL have port: busy  output  1  high in WAIT_VS and CAPTURE.
REQ-017 SHALL have port: done  output  1  one-cycle pulse on frame completion.
REQ-018 SHALL have port: wr_count  output  17  writes issued in current/last frame.
REQ-019 SHALL have port: frame_count  output  8  completed frames, wraps 255 -> 0.

Function
REQ-020 SHALL pass vsync_in and sample_in through two-flop synchronizers; vs_fall = synced vsync 1 -> 0 (one-cycle pulse), asserted 3 cycles after the input edge.
REQ-021 SHALL implement states IDLE, WAIT_VS, CAPTURE, DONE.
REQ-022 SHALL move IDLE -> WAIT_VS on arm; arm in any other state is ignored.
REQ-023 SHALL move WAIT_VS -> CAPTURE on vs_fall and clear wr_count to 0 in that cycle.
REQ-024 SHALL, in CAPTURE, qualify a write when visible=1, display_col < CAP_COLS, display_row < CAP_ROWS.
REQ-025 SHALL register outputs: wr_en, wr_addr, wr_data appear exactly 1 cycle after the qualifying cycle, wr_data = synced sample_in of the qualifying cycle.
REQ-026 SHALL force wr_en=0 in every state other than CAPTURE and for unqualified pixels.
REQ-027 SHALL increment wr_count by 1 per asserted wr_en; saturate at 65536 (no wrap).
REQ-028 SHALL move CAPTURE -> DONE on the next vs_fall (end of captured frame).
REQ-029 SHALL in DONE assert done for exactly one cycle, increment frame_count, then go to WAIT_VS if continuous=1, else IDLE.
REQ-030 SHALL, with continuous=1, treat the vs_fall that ended the frame as consumed; next capture starts at the following vs_fall (alternate frames captured).
REQ-031 SHALL give abort priority over all transitions: next state IDLE, wr_en=0 next cycle, no done pulse, frame_count unchanged, wr_count held.
REQ-032 SHALL, when arm and vs_fall coincide in IDLE, enter WAIT_VS only; capture starts at the subsequent vs_fall.
REQ-033 SHALL deassert busy in IDLE and DONE.

Reset
REQ-034 SHALL on reset: state IDLE, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, wr_count=0, frame_count=0, synchronizers cleared to vsync=1, sample=0.
REQ-035 SHALL, on reset mid-capture, drop wr_en within the reset cycle asynchronously and require a new arm after release.

Verification
REQ-036 SHALL cover: arm, two 256x256-visible frames of constant sample 3'b101 -> 65536 writes, addr {col,row}, data 101, one done, wr_count=65536, frame_count=1.
REQ-037 SHALL cover: 640x480 visible area -> writes only for col<256, row<256, wr_count=65536, no write at col=256 or row=256.
REQ-038 SHALL cover: continuous=1 over 5 frames -> captures frames 1 and 3 (after vs_fall 0 and 2), frame_count=2, done pulses 2.
REQ-039 SHALL cover: abort at row 100 -> wr_en 0 next cycle, state IDLE, done never asserted, frame_count=0, wr_count=25600.
REQ-040 SHALL cover: arm while busy and arm coincident with vs_fall in IDLE -> no state change / capture begins one frame later.
REQ-041 SHALL cover: reset asserted mid-CAPTURE -> all outputs zero immediately, stays IDLE until new arm.
